priority_encoder_pipe: RTL
==========================

# priority_encoder_pipe

Pipelined, parametrised priority encoder tree with a valid/ready stream interface. Each input word is a WIDTH-bit request vector. Each output is the index of the highest-priority set bit, plus an any-set flag. Priority direction (LSB-first or MSB-first) is chosen per word. The block replaces the combinational one-hot encoder tree wherever a wide vector must be encoded at full clock rate: one register stage per tree level, full throughput, lossless backpressure.

## Interface
- WIDTH, 16, request vector width; any value >= 2.
- SPLIT, 4, tree radix (children per node); power of two, >= 2.
- Derived: WIDTH_LOG = $clog2(WIDTH); SPLIT_LOG = $clog2(SPLIT); LEVELS = smallest L with SPLIT**L >= WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dec_vld  in  1  input word valid.
- dec_rdy  out  1  input word accepted when dec_vld && dec_rdy.
- dec_dat  in  WIDTH  request vector.
- dec_msb  in  1  priority mode for this word: 0 = lowest set index wins, 1 = highest set index wins.
- enc_vld  out  1  output word valid.
- enc_rdy  in  1  output word consumed when enc_vld && enc_rdy.
- enc_idx  out  WIDTH_LOG  encoded winning index.
- enc_any  out  1  1 when dec_dat had at least one bit set.

## Operation
- Input is zero-padded to SPLIT**LEVELS bits. Padding bits never win.
- Level 0 splits the padded vector into groups of SPLIT bits. Per group it produces:
  - any = OR of the group;
  - local index (SPLIT_LOG bits) of the first set bit (dec_msb=0) or last set bit (dec_msb=1).
- Level k>0 combines SPLIT child (any, idx) pairs:
  - selects the first (msb=0) or last (msb=1) child with any=1;
  - output idx = {selected child number, child idx};
  - output any = OR of child any.
- Each level's result is stored in a register stage together with a stage valid and the word's dec_msb bit. dec_msb travels with its word, so the mode may change every word.
- The final stage drives the outputs:
  - enc_any = root any;
  - enc_idx = root idx truncated to WIDTH_LOG bits;
  - when enc_any=0, enc_idx = 0 (defined, never X).
- Stall rule, for stage s = 0..LEVELS-1:
  - rdy_s = !vld_s || rdy_(s+1), with rdy_LEVELS = enc_rdy;
  - dec_rdy = rdy_0;
  - a stage loads when its upstream is valid and rdy_s=1;
  - a stage clears its valid when it is drained and nothing loads;
  - stage data registers load only on advance.
- Words are never dropped, duplicated or reordered.
- Encoding is pure priority. Multi-hot inputs are legal and resolve by mode. One-hot inputs give the same result in both modes.

## Timing
- Reset (rst_n=0, asynchronous):
  - all stage valids = 0, all stage data = 0;
  - enc_vld=0, enc_idx=0, enc_any=0, dec_rdy=1.
  - Release is synchronous to clk.
- Latency: a word accepted at edge n appears on enc_* after edge n+LEVELS-1, i.e. LEVELS cycles of register delay from input to output, when not stalled (WIDTH=16, SPLIT=4: 2 cycles).
- Throughput: one word per cycle while enc_rdy=1.
- dec_rdy is combinational from enc_rdy and the stage valids. No other input-to-output combinational path exists.
- Capacity: LEVELS words. With enc_rdy held 0, dec_rdy falls after LEVELS accepted words.
- Simultaneous accept and consume on a full pipeline: all stages advance in the same cycle with no bubble.
- enc_idx, enc_any and enc_vld hold stable while enc_vld=1 and enc_rdy=0.
- Reset mid-operation: in-flight words are discarded and the outputs take their reset values immediately. The first word after release behaves as from idle.

## Test plan
- Idle and zero: reset, then send dec_dat=0 with msb=0 and with msb=1 -> enc_vld after LEVELS cycles, enc_any=0, enc_idx=0.
- One-hot sweep, for WIDTH=16/SPLIT=4 and WIDTH=10/SPLIT=4 (padding case): bit i set, both modes, back-to-back -> enc_idx=i, enc_any=1, one result per cycle, in order.
- Multi-hot priority: 16'h8421 -> msb=0 gives 0, msb=1 gives 15. 16'h0180 -> 7 (msb=0) and 8 (msb=1). Modes alternate every word.
- Backpressure: enc_rdy=0 while streaming 5 words -> exactly LEVELS words accepted, dec_rdy=0. Outputs stay stable. On enc_rdy=1, all 5 words emerge in order, none lost or duplicated.
- Random stall: random dec_vld/enc_rdy over 10k words, checked against a reference priority function and a scoreboard -> zero mismatches, order preserved.
- Reset mid-stream: assert rst_n=0 with LEVELS words in flight -> enc_vld=0, dec_rdy=1 at once. After release, the next word returns the correct result with normal latency.

Source files
------------

// File: rtl/priority_encoder_pipe.sv
// Pipelined priority encoder tree with valid/ready handshake.
// One register stage per tree level; the final stage drives enc_* directly.
`timescale 1ns/1ps

module priority_encoder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPLIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dec_vld,
    output logic                     dec_rdy,
    input  logic [WIDTH-1:0]         dec_dat,
    input  logic                     dec_msb,
    output logic                     enc_vld,
    input  logic                     enc_rdy,
    output logic [$clog2(WIDTH)-1:0] enc_idx,
    output logic                     enc_any
);

    // Smallest L with s**L >= w.
    function automatic int unsigned calc_levels(input int unsigned w, input int unsigned s);
        int unsigned     lvl;
        longint unsigned span;
        lvl  = 1;
        span = 64'(s);
        while (span < 64'(w)) begin
            span = span * 64'(s);
            lvl++;
        end
        return lvl;
    endfunction

    localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
    localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
    localparam int unsigned LEVELS    = calc_levels(WIDTH, SPLIT);
    localparam int unsigned PAD_LOG   = SPLIT_LOG * LEVELS;
    localparam int unsigned PAD       = 1 << PAD_LOG;

    logic [LEVELS:0]   rdy;
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] up_vld;

    // Ready ripples backwards from the consumer through empty stages.
    always_comb begin
        rdy         = '0;
        rdy[LEVELS] = enc_rdy;
        for (int s = int'(LEVELS) - 1; s >= 0; s--) begin
            rdy[s] = !vld_q[s] || rdy[s+1];
        end
    end

    always_comb begin
        up_vld = LEVELS'({vld_q, dec_vld});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int s = 0; s < int'(LEVELS); s++) begin
                if (rdy[s]) begin
                    vld_q[s] <= up_vld[s];
                end
            end
        end
    end

    for (genvar s = 0; s < LEVELS; s++) begin : g_stg
        localparam int unsigned NODES = 1 << (SPLIT_LOG * (LEVELS - 1 - s));
        localparam int unsigned IW    = SPLIT_LOG * (s + 1);

        logic                     load;
        logic                     msb_in;
        logic [NODES-1:0]         any_d;
        logic [NODES-1:0]         any_q;
        logic [NODES-1:0][IW-1:0] idx_d;
        logic [NODES-1:0][IW-1:0] idx_q;

        assign load = up_vld[s] && rdy[s];

        if (s == 0) begin : g_leaf
            logic [PAD-1:0] pad;

            assign msb_in = dec_msb;
            assign pad    = PAD'(dec_dat);

            // Per group: scan in reverse priority order so the winner is written last.
            always_comb begin
                int b;
                b     = 0;
                any_d = '0;
                idx_d = '0;
                for (int n = 0; n < int'(NODES); n++) begin
                    any_d[n] = |pad[n*int'(SPLIT) +: int'(SPLIT)];
                    for (int j = 0; j < int'(SPLIT); j++) begin
                        b = msb_in ? j : int'(SPLIT) - 1 - j;
                        if (pad[n*int'(SPLIT) + b]) begin
                            idx_d[n] = IW'(b);
                        end
                    end
                end
            end
        end else begin : g_node
            logic [NODES*SPLIT-1:0]                   c_any;
            logic [NODES*SPLIT-1:0][IW-SPLIT_LOG-1:0] c_idx;

            assign msb_in = g_stg[s-1].g_msb.msb_q;
            assign c_any  = g_stg[s-1].any_q;
            assign c_idx  = g_stg[s-1].idx_q;

            // Pick the winning child and prepend its number to the child index.
            always_comb begin
                int c;
                c     = 0;
                any_d = '0;
                idx_d = '0;
                for (int n = 0; n < int'(NODES); n++) begin
                    any_d[n] = |c_any[n*int'(SPLIT) +: int'(SPLIT)];
                    for (int j = 0; j < int'(SPLIT); j++) begin
                        c = msb_in ? j : int'(SPLIT) - 1 - j;
                        if (c_any[n*int'(SPLIT) + c]) begin
                            idx_d[n] = {SPLIT_LOG'(c), c_idx[n*int'(SPLIT) + c]};
                        end
                    end
                end
            end
        end

        // Mode bit only needs to travel as far as the last combining level.
        if (s < LEVELS - 1) begin : g_msb
            logic msb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    msb_q <= 1'b0;
                end else if (load) begin
                    msb_q <= msb_in;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                any_q <= '0;
                idx_q <= '0;
            end else if (load) begin
                any_q <= any_d;
                idx_q <= idx_d;
            end
        end
    end

    assign dec_rdy = rdy[0];
    assign enc_vld = vld_q[LEVELS-1];
    assign enc_any = g_stg[LEVELS-1].any_q[0];
    assign enc_idx = g_stg[LEVELS-1].idx_q[0][WIDTH_LOG-1:0];

endmodule
